// File: rtl/program_counter_rs.sv
// rtl/program_counter_rs.sv - program counter with integrated return-address stack
//
// Fetch-address source for the CPU core. Supports absolute load, increment,
// PC-relative branch, subroutine call/return and pipeline stall.
//
// Ports:
//   CLK        system clock, all state updates on rising edge
//   RST_N      synchronous active-low reset
//   STALL      freeze PC and stack this cycle (ERR_CLR still honoured)
//   LOAD_PC    PC <= ADDRESS
//   INC_PC     PC <= PC + 1
//   BRANCH_PC  PC <= PC + OFFSET (two's complement)
//   CALL_PC    push PC+1, PC <= ADDRESS
//   RET_PC     PC <= popped return address
//   ERR_CLR    clear sticky STACK_OVF / STACK_UNF
//   ADDRESS    absolute target for LOAD/CALL
//   OFFSET     branch displacement
//   EXECADD    current PC (the PC register itself)
//   STACK_CNT  number of valid stack entries
//   STACK_OVF  sticky: CALL attempted with stack full
//   STACK_UNF  sticky: RET attempted with stack empty
module program_counter_rs #(
  parameter int                   WORD_SIZE    = 19,
  parameter int                   STACK_DEPTH  = 8,
  parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic                               STALL,
  input  logic                               LOAD_PC,
  input  logic                               INC_PC,
  input  logic                               BRANCH_PC,
  input  logic                               CALL_PC,
  input  logic                               RET_PC,
  input  logic                               ERR_CLR,
  input  logic [WORD_SIZE-1:0]               ADDRESS,
  input  logic [WORD_SIZE-1:0]               OFFSET,
  output logic [WORD_SIZE-1:0]               EXECADD,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   STACK_CNT,
  output logic                               STACK_OVF,
  output logic                               STACK_UNF
);

  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int AW = $clog2(STACK_DEPTH);

  logic [WORD_SIZE-1:0] stack_mem [STACK_DEPTH];

  logic [WORD_SIZE-1:0] pc_inc;
  logic [WORD_SIZE-1:0] pc_br;
  logic [AW-1:0]        push_idx;
  logic [AW-1:0]        pop_idx;
  logic                 stack_full;
  logic                 stack_empty;
  logic                 do_push;

  // Additions wrap modulo 2^WORD_SIZE by truncation; OFFSET's sign is
  // handled naturally by two's-complement addition.
  assign pc_inc      = EXECADD + WORD_SIZE'(1);
  assign pc_br       = EXECADD + OFFSET;
  assign stack_full  = (STACK_CNT == CW'(STACK_DEPTH));
  assign stack_empty = (STACK_CNT == '0);

  // The count doubles as the write pointer; top of stack sits one below it.
  // When full the push index aliases entry 0, but no push happens then.
  assign push_idx = STACK_CNT[AW-1:0];
  assign pop_idx  = AW'(STACK_CNT - CW'(1));

  // A push only happens when CALL wins priority and there is room.
  assign do_push = RST_N && !STALL && !RET_PC && CALL_PC && !stack_full;

  // Stack storage carries no reset: entries above STACK_CNT are never read.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      EXECADD   <= RESET_VECTOR;
      STACK_CNT <= '0;
      STACK_OVF <= 1'b0;
      STACK_UNF <= 1'b0;
    end else begin
      // Clear first so that an error event later in this block wins.
      if (ERR_CLR) begin
        STACK_OVF <= 1'b0;
        STACK_UNF <= 1'b0;
      end
      if (!STALL) begin
        if (RET_PC) begin
          if (stack_empty) begin
            STACK_UNF <= 1'b1;
          end else begin
            EXECADD   <= stack_mem[pop_idx];
            STACK_CNT <= STACK_CNT - CW'(1);
          end
        end else if (CALL_PC) begin
          if (stack_full) begin
            STACK_OVF <= 1'b1;
          end else begin
            EXECADD   <= ADDRESS;
            STACK_CNT <= STACK_CNT + CW'(1);
          end
        end else if (LOAD_PC) begin
          EXECADD <= ADDRESS;
        end else if (BRANCH_PC) begin
          EXECADD <= pc_br;
        end else if (INC_PC) begin
          EXECADD <= pc_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_program_counter_rs.sv
// tb/tb_program_counter_rs.sv - self-checking bench for program_counter_rs
module tb_program_counter_rs;

  localparam int W     = 19;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam int C_LD    = 1;
  localparam int C_INC   = 2;
  localparam int C_BR    = 4;
  localparam int C_CALL  = 8;
  localparam int C_RET   = 16;
  localparam int C_CLR   = 32;
  localparam int C_STALL = 64;
  localparam int C_RST   = 128;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          STALL = 1'b0;
  logic          LOAD_PC = 1'b0;
  logic          INC_PC = 1'b0;
  logic          BRANCH_PC = 1'b0;
  logic          CALL_PC = 1'b0;
  logic          RET_PC = 1'b0;
  logic          ERR_CLR = 1'b0;
  logic [W-1:0]  ADDRESS = '0;
  logic [W-1:0]  OFFSET = '0;
  logic [W-1:0]  EXECADD;
  logic [CW-1:0] STACK_CNT;
  logic          STACK_OVF;
  logic          STACK_UNF;

  program_counter_rs #(
    .WORD_SIZE   (W),
    .STACK_DEPTH (DEPTH),
    .RESET_VECTOR(19'h00000)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .STALL     (STALL),
    .LOAD_PC   (LOAD_PC),
    .INC_PC    (INC_PC),
    .BRANCH_PC (BRANCH_PC),
    .CALL_PC   (CALL_PC),
    .RET_PC    (RET_PC),
    .ERR_CLR   (ERR_CLR),
    .ADDRESS   (ADDRESS),
    .OFFSET    (OFFSET),
    .EXECADD   (EXECADD),
    .STACK_CNT (STACK_CNT),
    .STACK_OVF (STACK_OVF),
    .STACK_UNF (STACK_UNF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0]  pc;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          unf;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [W-1:0] m_pc = '0;
  logic [W-1:0] m_stk[$];
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;

  task automatic model(input int c, input logic [W-1:0] addr, input logic [W-1:0] off);
    logic [W-1:0] ret_addr;
    if ((c & C_RST) != 0) begin
      m_pc = 19'h00000;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if ((c & C_CLR) != 0) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if ((c & C_STALL) == 0) begin
        if ((c & C_RET) != 0) begin
          if (m_stk.size() == 0) m_unf = 1'b1;
          else m_pc = m_stk.pop_back();
        end else if ((c & C_CALL) != 0) begin
          if (m_stk.size() == DEPTH) m_ovf = 1'b1;
          else begin
            ret_addr = m_pc + 19'd1;
            m_stk.push_back(ret_addr);
            m_pc = addr;
          end
        end else if ((c & C_LD) != 0) m_pc = addr;
        else if ((c & C_BR) != 0) m_pc = m_pc + off;
        else if ((c & C_INC) != 0) m_pc = m_pc + 19'd1;
      end
    end
  endtask

  task automatic step(input string tag, input int c, input logic [W-1:0] addr,
                      input logic [W-1:0] off);
    exp_t e;
    RST_N     = ((c & C_RST) == 0);
    STALL     = ((c & C_STALL) != 0);
    LOAD_PC   = ((c & C_LD) != 0);
    INC_PC    = ((c & C_INC) != 0);
    BRANCH_PC = ((c & C_BR) != 0);
    CALL_PC   = ((c & C_CALL) != 0);
    RET_PC    = ((c & C_RET) != 0);
    ERR_CLR   = ((c & C_CLR) != 0);
    ADDRESS   = addr;
    OFFSET    = off;
    model(c, addr, off);
    e.pc  = m_pc;
    e.cnt = CW'(m_stk.size());
    e.ovf = m_ovf;
    e.unf = m_unf;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    vectors++;
    assert (EXECADD === e.pc) else begin
      miscompares++;
      $error("FAIL %s pc: got %h expected %h", tag, EXECADD, e.pc);
    end
    vectors++;
    assert (STACK_CNT === e.cnt) else begin
      miscompares++;
      $error("FAIL %s cnt: got %0d expected %0d", tag, STACK_CNT, e.cnt);
    end
    vectors++;
    assert (STACK_OVF === e.ovf) else begin
      miscompares++;
      $error("FAIL %s ovf: got %b expected %b", tag, STACK_OVF, e.ovf);
    end
    vectors++;
    assert (STACK_UNF === e.unf) else begin
      miscompares++;
      $error("FAIL %s unf: got %b expected %b", tag, STACK_UNF, e.unf);
    end
  endtask

  // Direct check against a fixed value taken from the test plan.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    // 1. reset and increment
    step("rst0", C_RST, '0, '0);
    step("rst1", C_RST, '0, '0);
    chk("rst_pc", 32'(EXECADD), 32'h0);
    chk("rst_cnt", 32'(STACK_CNT), 32'h0);
    step("inc1", C_INC, '0, '0);
    chk("inc1_pc", 32'(EXECADD), 32'h1);
    step("inc2", C_INC, '0, '0);
    step("inc3", C_INC, '0, '0);
    chk("inc3_pc", 32'(EXECADD), 32'h3);

    // 2. wrap and branch
    step("ld_max", C_LD, 19'h7FFFF, '0);
    step("wrap", C_INC, '0, '0);
    chk("wrap_pc", 32'(EXECADD), 32'h0);
    step("br_neg", C_BR, '0, 19'h7FFFE);
    chk("br_neg_pc", 32'(EXECADD), 32'h7FFFE);
    step("br_pos", C_BR, '0, 19'h00005);
    chk("br_pos_pc", 32'(EXECADD), 32'h3);
    step("idle", 0, 19'h11111, 19'h00022);
    chk("idle_pc", 32'(EXECADD), 32'h3);
    step("ld_beats_br", C_LD | C_BR | C_INC, 19'h0ABCD, 19'h00010);

    // 3. nested call/return
    step("ld100", C_LD, 19'h00100, '0);
    step("call200", C_CALL, 19'h00200, '0);
    step("call300", C_CALL, 19'h00300, '0);
    chk("nest_cnt", 32'(STACK_CNT), 32'h2);
    step("ret1", C_RET, '0, '0);
    chk("ret1_pc", 32'(EXECADD), 32'h201);
    step("ret2", C_RET, '0, '0);
    chk("ret2_pc", 32'(EXECADD), 32'h101);
    chk("ret2_cnt", 32'(STACK_CNT), 32'h0);

    // 4. overflow / underflow
    for (int i = 1; i <= DEPTH; i++) begin
      step($sformatf("fill%0d", i), C_CALL, W'(i * 16), '0);
    end
    step("call_ovf", C_CALL, 19'h12345, '0);
    chk("ovf_pc", 32'(EXECADD), 32'h80);
    chk("ovf_cnt", 32'(STACK_CNT), 32'h8);
    chk("ovf_flag", 32'(STACK_OVF), 32'h1);
    step("ovf_sticky", C_INC, '0, '0);
    step("rst_b", C_RST, '0, '0);
    step("ret_unf", C_RET, '0, '0);
    chk("unf_pc", 32'(EXECADD), 32'h0);
    chk("unf_flag", 32'(STACK_UNF), 32'h1);
    step("clr", C_CLR, '0, '0);
    chk("clr_unf", 32'(STACK_UNF), 32'h0);

    // 5. priority and stall
    step("ld4f", C_LD, 19'h0004F, '0);
    step("call80", C_CALL, 19'h00080, '0);
    step("prio", C_RET | C_CALL | C_INC, 19'h01234, '0);
    chk("prio_pc", 32'(EXECADD), 32'h50);
    chk("prio_cnt", 32'(STACK_CNT), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("stall%0d", i), C_STALL | C_INC, '0, '0);
    end
    chk("stall_pc", 32'(EXECADD), 32'h50);
    step("stall_ret_empty", C_STALL | C_RET, '0, '0);
    chk("stall_no_unf", 32'(STACK_UNF), 32'h0);
    step("stall_call", C_STALL | C_CALL, 19'h00999, '0);
    step("ret_empty", C_RET, '0, '0);
    step("clr_and_unf", C_CLR | C_RET, '0, '0);
    chk("set_wins", 32'(STACK_UNF), 32'h1);
    step("clr_in_stall", C_CLR | C_STALL, '0, '0);
    chk("stall_clr", 32'(STACK_UNF), 32'h0);

    // 6. reset mid-operation
    step("c400", C_CALL, 19'h00400, '0);
    step("c500", C_CALL, 19'h00500, '0);
    step("c600", C_CALL, 19'h00600, '0);
    step("rst_ret", C_RST | C_RET, '0, '0);
    chk("mid_rst_pc", 32'(EXECADD), 32'h0);
    chk("mid_rst_cnt", 32'(STACK_CNT), 32'h0);
    step("ret_after_rst", C_RET, '0, '0);
    chk("mid_rst_unf", 32'(STACK_UNF), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/program_counter_rs.md
Name: program_counter_rs

Overview:
Parametrised program counter with an integrated hardware return-address stack. It is the fetch-address source for the CPU core. It supports absolute load, increment, PC-relative branch, subroutine call/return and pipeline stall. It exposes stack occupancy and sticky overflow/underflow flags to the control unit.

Parameters:
WORD_SIZE, 19, width of PC, ADDRESS, OFFSET and stack entries
STACK_DEPTH, 8, number of return-address entries (>=2)
RESET_VECTOR, 0, PC value after reset (WORD_SIZE bits)

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST_N  input  1  synchronous active-low reset
STALL  input  1  freeze PC and stack this cycle
LOAD_PC  input  1  PC <= ADDRESS
INC_PC  input  1  PC <= PC + 1
BRANCH_PC  input  1  PC <= PC + OFFSET
CALL_PC  input  1  push PC+1, PC <= ADDRESS
RET_PC  input  1  PC <= popped return address
ERR_CLR  input  1  clear sticky STACK_OVF / STACK_UNF
ADDRESS  input  WORD_SIZE  absolute target for LOAD/CALL
OFFSET  input  WORD_SIZE  two's-complement branch displacement
EXECADD  output  WORD_SIZE  current PC (registered)
STACK_CNT  output  $clog2(STACK_DEPTH+1)  valid stack entries
STACK_OVF  output  1  sticky: CALL attempted with stack full
STACK_UNF  output  1  sticky: RET attempted with stack empty

Behaviour:
- Reset (RST_N=0 at edge) beats all other inputs. It sets EXECADD=RESET_VECTOR, STACK_CNT=0, STACK_OVF=0 and STACK_UNF=0. Stack RAM contents are don't-care.
- EXECADD is the PC register itself, with no extra pipeline stage. A command sampled at edge N is visible on EXECADD immediately after edge N.
- STALL=1 holds PC, stack and STACK_CNT, and no error flags are set. ERR_CLR still acts during STALL.
- Command priority when STALL=0: RET_PC > CALL_PC > LOAD_PC > BRANCH_PC > INC_PC. Lower-priority strobes in the same cycle are ignored.
- No strobe asserted: PC holds its value. It is not cleared.
- INC: PC+1 modulo 2^WORD_SIZE, so max value wraps to 0.
- BRANCH: PC+OFFSET modulo 2^WORD_SIZE. OFFSET is sign-interpreted, and overflow is not flagged.
- CALL, stack not full: write (PC+1) mod 2^WORD_SIZE at top, STACK_CNT+1, PC<=ADDRESS.
- CALL, stack full (STACK_CNT==STACK_DEPTH): whole CALL discarded. PC, stack and count unchanged. STACK_OVF<=1.
- RET, stack not empty: PC<=top entry, STACK_CNT-1.
- RET, stack empty: PC and count unchanged. STACK_UNF<=1.
- Stack is LIFO, implemented as a register array indexed by STACK_CNT. No read latency: the popped value lands on EXECADD the same edge.
- Sticky flags: set on their event, cleared only by ERR_CLR or reset. If ERR_CLR and a new error event occur in the same cycle, set wins.
- Reset mid-sequence (e.g. during nested calls) discards all stack state immediately. No partial pop or push completes.

Test Plan:
1. Reset and increment: RST_N=0 for 2 cycles, then INC_PC=1 for 3 cycles -> EXECADD 0x00000 during reset, then 0x00001, 0x00002, 0x00003. STACK_CNT=0, both flags 0.
2. Wrap and branch: LOAD_PC with ADDRESS=0x7FFFF, then INC -> EXECADD 0x00000. Then BRANCH with OFFSET=0x7FFFE (-2) -> 0x7FFFE. Then BRANCH with OFFSET=0x00005 -> 0x00003.
3. Nested call/return: PC=0x00100, CALL ADDRESS=0x00200, then CALL ADDRESS=0x00300 -> STACK_CNT=2. Then RET -> EXECADD 0x00201, RET -> 0x00101, STACK_CNT=0.
4. Overflow/underflow: perform 8 CALLs, then a 9th CALL with ADDRESS=0x12345 -> PC unchanged, STACK_CNT=8, STACK_OVF=1. Reset, then RET -> PC=0x00000, STACK_UNF=1. Then ERR_CLR -> STACK_UNF=0.
5. Priority and stall: assert RET_PC+CALL_PC+INC_PC together with 1 entry (0x00050) -> EXECADD=0x00050, STACK_CNT=0. Then STALL=1 with INC_PC=1 for 3 cycles -> EXECADD held at 0x00050. Then ERR_CLR with a simultaneous RET on empty stack -> STACK_UNF stays 1.
6. Reset mid-operation: 3 CALLs, then RST_N=0 for one cycle coinciding with RET_PC=1 -> EXECADD=RESET_VECTOR, STACK_CNT=0. A following RET sets STACK_UNF=1.
